pipe_hazard_ctrl: RTL

- Central hazard controller for the 5-stage RISC-V pipeline.
- Drives the stall/enable and clear inputs of the IF/ID, ID/EX and EX/MEM pipeline registers, and the EX-stage forwarding muxes.
- Sequences multi-cycle load-use stalls and data-memory wait states with a small FSM.
- Keeps saturating stall and flush counters for debug.

---
 rtl/pipe_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central hazard controller for the 5-stage RISC-V pipeline. It drives the
//   hold/clear controls of the IF/ID, ID/EX and EX/MEM registers and selects
//   the EX-stage forwarding sources. A small FSM sequences multi-cycle
//   load-use bubbles and data-memory wait states. Two saturating counters
//   record stall cycles and taken-branch flushes for debug.
//
// Ports
//   Clk, Rst                   clock (rising edge), synchronous active-high reset
//   Rs1D, Rs2D                 source registers of the instruction in ID
//   Rs1E, Rs2E                 source registers of the instruction in EX
//   RdE, RdM, RdW              destination registers in EX / MEM / WB
//   RegWriteM, RegWriteW       register-write enables in MEM / WB
//   LoadE                      EX instruction is a load
//   PCSrcE                     branch/jump taken, resolved in EX
//   MemReqM, MemReadyM         data-memory request active / completing in MEM
//   StallF, StallD, StallE,
//   StallM                     hold PC, IF/ID, ID/EX, EX/MEM
//   FlushD, FlushE             clear IF/ID, clear ID/EX
//   ForwardAE, ForwardBE       00 regfile, 01 WB result, 10 MEM ALU result
//   StallCnt                   saturating count of cycles with StallD=1
//   FlushCnt                   saturating count of taken-branch flushes
//   State                      FSM state, for debug
//
// FSM states
//   state   | meaning
//   --------+---------------------------------------------------------------
//   RUN     | normal issue; single-cycle hazards resolved here
//   LDSTALL | extra load-use bubbles, cnt counts down to terminal value 1
//   MEMWAIT | data memory busy; whole front of the pipe frozen

module pipe_hazard_ctrl #(
  parameter int CNT_W          = 16,
  parameter int LOAD_STALL_CYC = 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             LoadE,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             StallE,
  output logic             FlushE,
  output logic             StallM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [1:0]       State
);

  localparam logic [1:0] RUN     = 2'b00;
  localparam logic [1:0] LDSTALL = 2'b01;
  localparam logic [1:0] MEMWAIT = 2'b10;

  // A single-cycle load stall never leaves RUN, so the countdown is only
  // loaded when more than one bubble is needed.
  localparam bit         MULTI_LD = (LOAD_STALL_CYC > 1);
  localparam logic [2:0] CNT_LD   = 3'(LOAD_STALL_CYC - 1);

  logic [1:0]       state_q, state_nxt;
  logic [2:0]       cnt_q, cnt_nxt;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic             lu;
  logic             mem_wait;
  logic             flush_br;

  assign lu       = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_wait = MemReqM && !MemReadyM;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_nxt = MEMWAIT;
        end else if (PCSrcE) begin
          state_nxt = RUN;
        end else if (lu && MULTI_LD) begin
          state_nxt = LDSTALL;
          cnt_nxt   = CNT_LD;
        end
      end
      LDSTALL: begin
        if (mem_wait) begin
          // memory wait wins; outstanding bubbles are abandoned
          state_nxt = MEMWAIT;
          cnt_nxt   = 3'd0;
        end else if (PCSrcE) begin
          state_nxt = RUN;
          cnt_nxt   = 3'd0;
        end else begin
          cnt_nxt = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 3'd0;
          end
        end
      end
      MEMWAIT: begin
        // a taken branch is held in the frozen EX stage and handled after exit
        if (MemReadyM) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------
  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    StallM   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    flush_br = 1'b0;
    if (Rst) begin
      // squash whatever is in flight while reset is held
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else begin
      case (state_q)
        RUN, LDSTALL: begin
          if (mem_wait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
          end else if (PCSrcE) begin
            // the ID instruction is squashed, so a load-use on it is moot
            FlushD   = 1'b1;
            FlushE   = 1'b1;
            flush_br = 1'b1;
          end else if (lu || (state_q == LDSTALL)) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
          end
        end
        MEMWAIT: begin
          StallF = 1'b1;
          StallD = 1'b1;
          StallE = 1'b1;
          StallM = 1'b1;
        end
        default: begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Forwarding: MEM result is newer than WB, so it wins on a double match
  // ---------------------------------------------------------------------
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!Rst) begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E)) begin
        ForwardAE = 2'b10;
      end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) begin
        ForwardAE = 2'b01;
      end
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E)) begin
        ForwardBE = 2'b10;
      end else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) begin
        ForwardBE = 2'b01;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Debug counters, saturating at all-ones
  // ---------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallD && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_br && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;
  assign State    = state_q;

endmodule
